// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared types and constants for the USB bulk OUT endpoint.
//   ep_state_e  receive FSM states (IDLE, RECV, DECIDE)
//   usb_rx_t    bundled controller rx-interface signals
//   EP_W        endpoint-number width
//   MAX_PKT_*   bulk max-packet sizes for full speed / high speed
//   ep_match()  endpoint filter: OUT/DATA token on our endpoint, not SETUP
package usb_ep_pkg;

  localparam int EP_W       = 4;
  localparam int MAX_PKT_FS = 64;
  localparam int MAX_PKT_HS = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DECIDE = 2'd2
  } ep_state_e;

  typedef struct packed {
    logic [7:0]      dat;
    logic            val;
    logic            act;
    logic            pktval;
    logic            setup;
    logic [EP_W-1:0] endpt;
  } usb_rx_t;

  function automatic logic ep_match(input logic [EP_W-1:0] endpt,
                                    input logic            setup,
                                    input logic [EP_W-1:0] ep);
    return (endpt == ep) && !setup;
  endfunction

endpackage

// File: rtl/usb_ep_sdpram.sv
// usb_ep_sdpram: simple dual-port byte RAM, one write port and one read port,
// both on clk_i. Read data is registered (1-cycle latency) and only updates
// when re_i is high, so it maps onto block RAM with output enable.
//   clk_i    clock
//   we_i     write enable; wdata_i stored at waddr_i
//   re_i     read enable;  rdata_o <= mem[raddr_i] on the next edge
//   rdata_o  registered read data
module usb_ep_sdpram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/usb_bulk_out_ep.sv
// usb_bulk_out_ep: bulk OUT endpoint receive buffer behind the USB device
// controller rx interface. Bytes of a matching packet are written
// speculatively into a circular RAM; the packet is committed only if the
// controller flags it valid and it fit, otherwise the write pointer rolls back.
// Committed bytes stream out on a valid/ready interface.
//
// Ports:
//   clk_i, reset_i            controller clock, async active-high reset
//   usb_rx*_i, usb_setup_i,
//   usb_endpt_i               controller rx interface
//   usb_rxrdy_o               room for a full MAX_PKT packet (low = NAK)
//   m_data_o/m_valid_o/
//   m_ready_i                 committed byte stream to the application
//   overflow_o                sticky: a packet was dropped for lack of space
//   clr_i                     synchronous flush of buffer and overflow_o
//   level_o                   committed bytes not yet taken by the application
//
// Optional build macro USB_EP_PKTCNT_EN: adds pkt_cnt_o (committed packets)
// and drop_cnt_o (rolled-back packets) 16-bit wrapping counters.
module usb_bulk_out_ep
  import usb_ep_pkg::*;
#(
  parameter logic [EP_W-1:0] EP_NUM     = 4'd2,
  parameter int              DEPTH_LOG2 = 10,
  parameter int              MAX_PKT    = MAX_PKT_HS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            usb_rxdat_i,
  input  logic                  usb_rxval_i,
  input  logic                  usb_rxact_i,
  input  logic                  usb_rxpktval_i,
  input  logic                  usb_setup_i,
  input  logic [EP_W-1:0]       usb_endpt_i,
  output logic                  usb_rxrdy_o,
  output logic [7:0]            m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  overflow_o,
  input  logic                  clr_i,
  output logic [DEPTH_LOG2:0]   level_o
`ifdef USB_EP_PKTCNT_EN
  ,
  output logic [15:0]           pkt_cnt_o,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int             PW     = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]  CAP    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0]  PKT_TH = PW'(MAX_PKT);
  localparam logic [PW-1:0]  ONE    = PW'(1);

  usb_rx_t rx;
  assign rx = '{dat: usb_rxdat_i, val: usb_rxval_i, act: usb_rxact_i,
                pktval: usb_rxpktval_i, setup: usb_setup_i, endpt: usb_endpt_i};

  // ---------------------------------------------------------------- rx side
  ep_state_e     state, state_nxt;
  logic          rxact_q, rx_rise, ep_hit;
  logic [PW-1:0] wr_commit, wr_spec, rd, used, free;
  logic          full, pkt_ok, drop, commit_ok, ram_we;

  // Pointers carry a wrap bit, so the difference is the true occupancy.
  assign used      = wr_spec - rd;
  assign free      = CAP - used;
  assign full      = (used == CAP);
  assign rx_rise   = rx.act && !rxact_q;
  assign ep_hit    = ep_match(rx.endpt, rx.setup, EP_NUM);
  assign commit_ok = pkt_ok && !drop;

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    case (state)
      IDLE:    if (rx_rise && ep_hit) state_nxt = RECV;
      RECV: begin
        ram_we = rx.val && !full;
        if (!rx.act) state_nxt = DECIDE;
      end
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    state <= IDLE;
    else if (clr_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // Resetting the edge detector high means a packet already in flight when
  // reset releases never looks like a fresh rxact rise. clr_i needs no such
  // trick: rxact_q keeps tracking, so a packet interrupted by clr_i stays high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rxact_q <= 1'b1;
    else         rxact_q <= rx.act;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_commit  <= '0;
      wr_spec    <= '0;
      pkt_ok     <= 1'b0;
      drop       <= 1'b0;
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_commit  <= '0;
      wr_spec    <= '0;
      pkt_ok     <= 1'b0;
      drop       <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (ram_we)                wr_spec <= wr_spec + ONE;
          if (rx.val && full)        drop    <= 1'b1;
          if (rx.pktval)             pkt_ok  <= 1'b1;
        end
        DECIDE: begin
          if (commit_ok) wr_commit <= wr_spec;
          else           wr_spec   <= wr_commit;
          if (drop)      overflow_o <= 1'b1;
          pkt_ok <= 1'b0;
          drop   <= 1'b0;
        end
        default: begin
          pkt_ok <= 1'b0;
          drop   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    usb_rxrdy_o <= 1'b1;
    else if (clr_i) usb_rxrdy_o <= 1'b1;
    else            usb_rxrdy_o <= (state == IDLE) && (free >= PKT_TH);
  end

  // -------------------------------------------------------------- read side
  // Two byte slots downstream of the RAM (output register + skid) absorb the
  // one read in flight, so m_ready_i can drop without losing a byte while
  // still allowing one byte per cycle. A RAM slot is freed as soon as its
  // byte is fetched; level_o adds the fetched-but-unread bytes back in.
  logic       rd_pend, skid_vld, pop, fetch;
  logic [7:0] skid_dat, ram_q;
  logic [1:0] occ, occ_after;

  assign pop       = m_valid_o && m_ready_i;
  assign occ       = {1'b0, m_valid_o} + {1'b0, skid_vld} + {1'b0, rd_pend};
  assign occ_after = occ - {1'b0, pop};
  assign fetch     = (rd != wr_commit) && (occ_after < 2'd2);
  assign level_o   = (wr_commit - rd) + {{(PW-2){1'b0}}, occ};

  usb_ep_sdpram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_spec[DEPTH_LOG2-1:0]),
    .wdata_i (rx.dat),
    .re_i    (fetch),
    .raddr_i (rd[DEPTH_LOG2-1:0]),
    .rdata_o (ram_q)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd        <= '0;
      rd_pend   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
    end else if (clr_i) begin
      rd        <= '0;
      rd_pend   <= 1'b0;
      skid_vld  <= 1'b0;
      m_valid_o <= 1'b0;
    end else begin
      rd_pend <= fetch;
      if (fetch) rd <= rd + ONE;
      if (!m_valid_o || pop) begin
        // Oldest byte first: skid, then whatever the RAM just returned.
        if (skid_vld) begin
          m_valid_o <= 1'b1;
          m_data_o  <= skid_dat;
          skid_vld  <= rd_pend;
          if (rd_pend) skid_dat <= ram_q;
        end else if (rd_pend) begin
          m_valid_o <= 1'b1;
          m_data_o  <= ram_q;
        end else begin
          m_valid_o <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_vld <= 1'b1;
        skid_dat <= ram_q;
      end
    end
  end

`ifdef USB_EP_PKTCNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (state == DECIDE) begin
      if (commit_ok) pkt_cnt_o  <= pkt_cnt_o + 16'd1;
      else           drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_bulk_out_ep.sv
// Directed bench for usb_bulk_out_ep (default build, counters absent).
module tb_usb_bulk_out_ep;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  usb_rxdat_i = '0;
  logic        usb_rxval_i = 1'b0;
  logic        usb_rxact_i = 1'b0;
  logic        usb_rxpktval_i = 1'b0;
  logic        usb_setup_i = 1'b0;
  logic [3:0]  usb_endpt_i = '0;
  logic        usb_rxrdy_o;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic        overflow_o;
  logic        clr_i = 1'b0;
  logic [10:0] level_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];
  logic       rnd_rdy = 1'b0;
  logic       rdy_low = 1'b0;

  always #8 clk_i = ~clk_i;

  usb_bulk_out_ep #(.EP_NUM(4'd2), .DEPTH_LOG2(10), .MAX_PKT(512)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .usb_rxdat_i    (usb_rxdat_i),
    .usb_rxval_i    (usb_rxval_i),
    .usb_rxact_i    (usb_rxact_i),
    .usb_rxpktval_i (usb_rxpktval_i),
    .usb_setup_i    (usb_setup_i),
    .usb_endpt_i    (usb_endpt_i),
    .usb_rxrdy_o    (usb_rxrdy_o),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .overflow_o     (overflow_o),
    .clr_i          (clr_i),
    .level_o        (level_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rnd_rdy) m_ready_i = 1'($urandom_range(0, 1));
  endtask

  // Every byte the application takes must be the next one the bench committed.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (!usb_rxrdy_o) rdy_low = 1'b1;
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL stream_extra: observed %0h expected none", m_data_o);
        end else begin
          chk("stream", 32'(m_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_pkt(input logic [3:0] ep, input logic setup, input int len,
                          input logic [7:0] first, input logic ok, input logic exp_commit);
    usb_endpt_i = ep;
    usb_setup_i = setup;
    usb_rxact_i = 1'b1;
    step();
    for (int i = 0; i < len; i++) begin
      usb_rxval_i = 1'b1;
      usb_rxdat_i = 8'(first + i);
      step();
    end
    usb_rxval_i    = 1'b0;
    usb_rxact_i    = 1'b0;
    usb_rxpktval_i = ok;
    step();
    usb_rxpktval_i = 1'b0;
    usb_setup_i    = 1'b0;
    step();
    if (exp_commit)
      for (int i = 0; i < len; i++) exp_q.push_back(8'(first + i));
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
  endtask

  task automatic wait_rdy(input int bound);
    int n = 0;
    while (!usb_rxrdy_o && n < bound) begin
      step();
      n++;
    end
    chk("rxrdy_wait", 32'(usb_rxrdy_o), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    #20;
    chk("rst_rxrdy", 32'(usb_rxrdy_o), 32'd1);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    step(); step(); step();

    // 64-byte valid packet, check commit-to-output latency
    send_pkt(4'd2, 1'b0, 64, 8'h00, 1'b1, 1'b1);
    chk("t1_level", 32'(level_o), 32'd64);
    chk("t1_vld_c0", 32'(m_valid_o), 32'd0);
    step();
    chk("t1_vld_c1", 32'(m_valid_o), 32'd0);
    step();
    chk("t1_vld_c2", 32'(m_valid_o), 32'd1);
    chk("t1_first", 32'(m_data_o), 32'h00);
    wait_drain("t1", 200);
    chk("t1_ovf", 32'(overflow_o), 32'd0);

    // CRC-fail packet rolled back, then a good one
    send_pkt(4'd2, 1'b0, 16, 8'h80, 1'b0, 1'b0);
    repeat (4) step();
    chk("t2_level", 32'(level_o), 32'd0);
    chk("t2_valid", 32'(m_valid_o), 32'd0);
    send_pkt(4'd2, 1'b0, 4, 8'hA0, 1'b1, 1'b1);
    wait_drain("t2", 50);

    // Other endpoint and SETUP are ignored
    rdy_low = 1'b0;
    send_pkt(4'd3, 1'b0, 32, 8'h40, 1'b1, 1'b0);
    send_pkt(4'd2, 1'b1, 8, 8'h50, 1'b1, 1'b0);
    repeat (4) step();
    chk("t3_level", 32'(level_o), 32'd0);
    chk("t3_valid", 32'(m_valid_o), 32'd0);
    chk("t3_rdy_low", 32'(rdy_low), 32'd0);
    chk("t3_rxrdy", 32'(usb_rxrdy_o), 32'd1);

    // Fill with the application stalled, then force an overflow
    m_ready_i = 1'b0;
    send_pkt(4'd2, 1'b0, 512, 8'h10, 1'b1, 1'b1);
    repeat (4) step();
    chk("t4_rdy1", 32'(usb_rxrdy_o), 32'd1);
    chk("t4_lvl1", 32'(level_o), 32'd512);
    send_pkt(4'd2, 1'b0, 512, 8'h55, 1'b1, 1'b1);
    repeat (4) step();
    chk("t4_rdy2", 32'(usb_rxrdy_o), 32'd0);
    chk("t4_lvl2", 32'(level_o), 32'd1024);
    chk("t4_hvld", 32'(m_valid_o), 32'd1);
    chk("t4_head", 32'(m_data_o), 32'h10);
    send_pkt(4'd2, 1'b0, 512, 8'hC0, 1'b1, 1'b0);
    repeat (4) step();
    chk("t4_ovf", 32'(overflow_o), 32'd1);
    chk("t4_lvl3", 32'(level_o), 32'd1024);
    chk("t4_head2", 32'(m_data_o), 32'h10);
    m_ready_i = 1'b1;
    wait_drain("t4", 2000);
    chk("t4_ovf_sticky", 32'(overflow_o), 32'd1);

    // Wrap-around: 2000-byte incrementing sequence, random backpressure
    rnd_rdy = 1'b1;
    for (int p = 0; p < 10; p++) begin
      wait_rdy(3000);
      send_pkt(4'd2, 1'b0, 200, 8'(p * 200), 1'b1, 1'b1);
    end
    wait_drain("t5", 6000);
    rnd_rdy   = 1'b0;
    m_ready_i = 1'b0;

    // clr_i mid-packet with committed data parked on the output
    send_pkt(4'd2, 1'b0, 8, 8'h20, 1'b1, 1'b1);
    repeat (4) step();
    chk("t6_pre_vld", 32'(m_valid_o), 32'd1);
    chk("t6_pre_ovf", 32'(overflow_o), 32'd1);
    exp_q.delete();
    usb_endpt_i = 4'd2;
    usb_setup_i = 1'b0;
    usb_rxact_i = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      usb_rxval_i = 1'b1;
      usb_rxdat_i = 8'(i);
      step();
    end
    clr_i       = 1'b1;
    usb_rxdat_i = 8'hEE;
    step();
    clr_i = 1'b0;
    chk("t6_lvl", 32'(level_o), 32'd0);
    chk("t6_ovf", 32'(overflow_o), 32'd0);
    chk("t6_vld", 32'(m_valid_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      usb_rxval_i = 1'b1;
      usb_rxdat_i = 8'(i + 8'hE0);
      step();
    end
    usb_rxval_i    = 1'b0;
    usb_rxact_i    = 1'b0;
    usb_rxpktval_i = 1'b1;
    step();
    usb_rxpktval_i = 1'b0;
    repeat (4) step();
    chk("t6_trail_lvl", 32'(level_o), 32'd0);
    chk("t6_trail_vld", 32'(m_valid_o), 32'd0);
    m_ready_i = 1'b1;
    send_pkt(4'd2, 1'b0, 5, 8'h30, 1'b1, 1'b1);
    wait_drain("t6", 50);
    chk("t6_ovf_end", 32'(overflow_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
